morse_key_sequencer: RTL

//  Turns a single raw straight-key input into the one-cycle dot/dash/char-space/word-space

---
 rtl/morse_key_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/morse_key_sequencer.sv
// morse_key_sequencer: synchronises and debounces a straight key, then emits one
// dot/dash strobe per key-down interval and char/word-space strobes per key-up interval.
module morse_key_sequencer #(
    parameter int UNIT_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic key_raw,
    output logic dot_out,
    output logic dash_out,
    output logic char_space_out,
    output logic word_space_out,
    output logic busy
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CHAR_GAP = CNT_W'(3 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_GAP = CNT_W'(7 * UNIT_CYCLES);

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    state_t          state;
    logic            s1, ks, kd;
    logic [DB_W-1:0] db_cnt;
    logic [CNT_W-1:0] cnt, cnt_inc;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            ks     <= 1'b0;
            kd     <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1 <= key_raw;
            ks <= s1;
            if (ks == kd)
                db_cnt <= '0;
            else if (db_cnt == DB_LAST) begin
                kd     <= ks;
                db_cnt <= '0;
            end else
                db_cnt <= db_cnt + 1'b1;
        end
    end

    // cnt counts kd-stable cycles of the current interval, loaded with 1 on entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            busy           <= 1'b0;
            dot_out        <= 1'b0;
            dash_out       <= 1'b0;
            char_space_out <= 1'b0;
            word_space_out <= 1'b0;
        end else begin
            dot_out        <= 1'b0;
            dash_out       <= 1'b0;
            char_space_out <= 1'b0;
            word_space_out <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (kd) begin
                        state <= PRESS;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                    PRESS: if (kd)
                        cnt <= cnt_inc;
                    else begin
                        dot_out  <= cnt < DASH_MIN;
                        dash_out <= cnt >= DASH_MIN;
                        state    <= GAP;
                        cnt      <= CNT_ONE;
                    end
                    GAP: begin
                        char_space_out <= cnt == CHAR_GAP;
                        word_space_out <= cnt == WORD_GAP;
                        // a new press wins over the return to IDLE, spaces still fire
                        if (kd) begin
                            state <= PRESS;
                            cnt   <= CNT_ONE;
                        end else if (cnt == WORD_GAP) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else
                            cnt <= cnt_inc;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
